// File: rtl/rrv64_sv39_ptw_if.sv
// Sv39 walker bus bundle: TLB miss request/response and PTE read port.
// The master side is the TLB arbiter plus memory; the slave side is the walker.
interface rrv64_sv39_ptw_if #(
  parameter int TRANS_ID_W = 4,
  parameter int PADDR_W    = 56,
  parameter int VPN_W      = 27,
  parameter int PPN_W      = 44
) ();
  logic [PPN_W-1:0]      satp_ppn;
  logic                  ptw_req_valid;
  logic                  ptw_req_ready;
  logic [TRANS_ID_W-1:0] ptw_req_trans_id;
  logic [VPN_W-1:0]      ptw_req_vpn;
  logic [1:0]            ptw_req_access_type;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [PADDR_W-1:0]    mem_req_paddr;
  logic                  mem_resp_valid;
  logic [63:0]           mem_resp_data;
  logic                  mem_resp_err;
  logic                  ptw_resp_valid;
  logic                  ptw_resp_ready;
  logic [TRANS_ID_W-1:0] ptw_resp_trans_id;
  logic                  ptw_resp_excp_valid;
  logic [3:0]            ptw_resp_excp_cause;
  logic [1:0]            ptw_resp_lvl;
  logic [63:0]           ptw_resp_pte;

  modport master (
    output satp_ppn, ptw_req_valid,
    output ptw_req_trans_id, ptw_req_vpn,
    output ptw_req_access_type,
    input  ptw_req_ready,
    input  mem_req_valid, mem_req_paddr,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data,
    output mem_resp_err,
    input  ptw_resp_valid, ptw_resp_trans_id,
    input  ptw_resp_excp_valid,
    input  ptw_resp_excp_cause,
    input  ptw_resp_lvl, ptw_resp_pte,
    output ptw_resp_ready
  );

  modport slave (
    input  satp_ppn, ptw_req_valid,
    input  ptw_req_trans_id, ptw_req_vpn,
    input  ptw_req_access_type,
    output ptw_req_ready,
    output mem_req_valid, mem_req_paddr,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data,
    input  mem_resp_err,
    output ptw_resp_valid, ptw_resp_trans_id,
    output ptw_resp_excp_valid,
    output ptw_resp_excp_cause,
    output ptw_resp_lvl, ptw_resp_pte,
    input  ptw_resp_ready
  );
endinterface

// File: rtl/rrv64_sv39_ptw.sv
// Sv39 page-table walker: one TLB miss at a time, up to three
// 8-byte PTE reads, returns the leaf PTE or a page/access fault.
module rrv64_sv39_ptw #(
  parameter int TRANS_ID_W = 4,
  parameter int PADDR_W    = 56,
  parameter int VPN_W      = 27,
  parameter int PPN_W      = 44
) (
  input logic clk,
  input logic rst_n,
  rrv64_sv39_ptw_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            lvl_q, lvl_d;
  logic [PPN_W-1:0]      base_q, base_d;
  logic [TRANS_ID_W-1:0] tid_q, tid_d;
  logic [VPN_W-1:0]      vpn_q, vpn_d;
  logic [1:0]            at_q, at_d;
  logic                  excp_q, excp_d;
  logic [3:0]            cause_q, cause_d;
  logic [1:0]            rlvl_q, rlvl_d;
  logic [63:0]           pte_q, pte_d;

  logic [8:0]  idx;
  logic [63:0] pte;
  logic [43:0] pte_ppn;
  logic        pte_v, pte_r, pte_w, pte_x;
  logic        pte_a, pte_d_bit;
  logic        is_st;
  logic        bad, leaf, misal, noacc;
  logic [3:0]  pf_cause, af_cause;

  always_comb begin
    idx = vpn_q[8:0];
    unique case (lvl_q)
      2'd2:    idx = vpn_q[26:18];
      2'd1:    idx = vpn_q[17:9];
      default: idx = vpn_q[8:0];
    endcase
  end

  assign pte       = bus.mem_resp_data;
  assign pte_ppn   = pte[53:10];
  assign pte_v     = pte[0];
  assign pte_r     = pte[1];
  assign pte_w     = pte[2];
  assign pte_x     = pte[3];
  assign pte_a     = pte[6];
  assign pte_d_bit = pte[7];
  assign is_st     = at_q[1];

  assign bad   = !pte_v || (!pte_r && pte_w)
               || (pte[63:54] != 10'd0);
  assign leaf  = pte_r || pte_x;
  assign misal = ((lvl_q == 2'd2) && (pte_ppn[17:0] != 18'd0))
              || ((lvl_q == 2'd1) && (pte_ppn[8:0] != 9'd0));
  // No hardware A/D update: software must pre-set them.
  assign noacc = !pte_a || (is_st && !pte_d_bit);

  always_comb begin
    pf_cause = 4'd15;
    af_cause = 4'd7;
    unique case (1'b1)
      (at_q == 2'b00): begin
        pf_cause = 4'd12;
        af_cause = 4'd1;
      end
      (at_q == 2'b01): begin
        pf_cause = 4'd13;
        af_cause = 4'd5;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    base_d  = base_q;
    tid_d   = tid_q;
    vpn_d   = vpn_q;
    at_d    = at_q;
    excp_d  = excp_q;
    cause_d = cause_q;
    rlvl_d  = rlvl_q;
    pte_d   = pte_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ptw_req_valid) begin
          tid_d   = bus.ptw_req_trans_id;
          vpn_d   = bus.ptw_req_vpn;
          at_d    = bus.ptw_req_access_type;
          base_d  = bus.satp_ppn;
          lvl_d   = 2'd2;
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (bus.mem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = RESP;
          rlvl_d  = lvl_q;
          excp_d  = 1'b1;
          cause_d = pf_cause;
          pte_d   = 64'd0;
          if (bus.mem_resp_err) begin
            cause_d = af_cause;
          end else if (bad) begin
            cause_d = pf_cause;
          end else if (!leaf && lvl_q != 2'd0) begin
            base_d  = pte_ppn[PPN_W-1:0];
            lvl_d   = lvl_q - 2'd1;
            state_d = MEM_REQ;
            excp_d  = excp_q;
            cause_d = cause_q;
            pte_d   = pte_q;
            rlvl_d  = rlvl_q;
          end else if (!leaf || misal || noacc) begin
            cause_d = pf_cause;
          end else begin
            excp_d  = 1'b0;
            cause_d = 4'd0;
            pte_d   = pte;
          end
        end
      end
      RESP: begin
        if (bus.ptw_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lvl_q   <= 2'd0;
      base_q  <= '0;
      tid_q   <= '0;
      vpn_q   <= '0;
      at_q    <= 2'd0;
      excp_q  <= 1'b0;
      cause_q <= 4'd0;
      rlvl_q  <= 2'd0;
      pte_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      base_q  <= base_d;
      tid_q   <= tid_d;
      vpn_q   <= vpn_d;
      at_q    <= at_d;
      excp_q  <= excp_d;
      cause_q <= cause_d;
      rlvl_q  <= rlvl_d;
      pte_q   <= pte_d;
    end
  end

  assign bus.ptw_req_ready       = (state_q == IDLE);
  assign bus.mem_req_valid       = (state_q == MEM_REQ);
  assign bus.mem_req_paddr       = PADDR_W'({base_q, 12'd0})
                                 + PADDR_W'({idx, 3'd0});
  assign bus.ptw_resp_valid      = (state_q == RESP);
  assign bus.ptw_resp_trans_id   = tid_q;
  assign bus.ptw_resp_excp_valid = excp_q;
  assign bus.ptw_resp_excp_cause = cause_q;
  assign bus.ptw_resp_lvl        = rlvl_q;
  assign bus.ptw_resp_pte        = pte_q;

endmodule

// File: tb/tb_rrv64_sv39_ptw.sv
// Directed bench for the Sv39 walker: vector table of walks plus
// backpressure and mid-walk reset sequences.
module tb_rrv64_sv39_ptw;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rrv64_sv39_ptw_if bus ();

  rrv64_sv39_ptw dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [3:0]        tid;
    logic [26:0]       vpn;
    logic [1:0]        at;
    logic [43:0]       satp;
    logic [1:0]        n;
    logic [2:0][55:0]  a;
    logic [2:0][63:0]  d;
    logic [2:0]        err;
    logic              ex;
    logic [3:0]        cause;
    logic [1:0]        lvl;
    logic [63:0]       pte;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] tid, input logic [1:0] at, input logic [1:0] n,
    input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
    input logic [2:0] err, input logic ex, input logic [3:0] cause,
    input logic [1:0] lvl, input logic [63:0] pte);
    vec_t v;
    v.tid   = tid;
    v.vpn   = 27'h0040201;
    v.at    = at;
    v.satp  = 44'h80000;
    v.n     = n;
    v.a[0]  = 56'h80000008;
    v.a[1]  = 56'h80001008;
    v.a[2]  = 56'h80002008;
    v.d[0]  = d0;
    v.d[1]  = d1;
    v.d[2]  = d2;
    v.err   = err;
    v.ex    = ex;
    v.cause = cause;
    v.lvl   = lvl;
    v.pte   = pte;
    return v;
  endfunction

  task automatic send_req(input vec_t v);
    @(negedge clk);
    bus.ptw_req_valid       = 1'b1;
    bus.ptw_req_trans_id    = v.tid;
    bus.ptw_req_vpn         = v.vpn;
    bus.ptw_req_access_type = v.at;
    bus.satp_ppn            = v.satp;
    chk("req_ready_idle", bus.ptw_req_ready, 1);
    @(negedge clk);
    bus.ptw_req_valid = 1'b0;
    bus.satp_ppn      = ~v.satp;
    chk("memreq_lat", bus.mem_req_valid, 1);
  endtask

  task automatic serve_read(input logic [55:0] a, input logic [63:0] d,
                            input logic e);
    int k = 0;
    while (!bus.mem_req_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("memreq_seen", bus.mem_req_valid, 1);
    chk("paddr", bus.mem_req_paddr, a);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = d;
    bus.mem_resp_err   = e;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_err   = 1'b0;
  endtask

  task automatic check_resp(input vec_t v);
    int k = 0;
    chk("resp_lat", bus.ptw_resp_valid, 1);
    while (!bus.ptw_resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("resp_tid", bus.ptw_resp_trans_id, v.tid);
    chk("resp_ex", bus.ptw_resp_excp_valid, v.ex);
    if (v.ex) chk("resp_cause", bus.ptw_resp_excp_cause, v.cause);
    chk("resp_lvl", bus.ptw_resp_lvl, v.lvl);
    chk("resp_pte", bus.ptw_resp_pte, v.pte);
    @(negedge clk);
    chk("resp_done", bus.ptw_resp_valid, 0);
    chk("idle_again", bus.ptw_req_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    send_req(v);
    for (int i = 0; i < int'(v.n); i++)
      serve_read(v.a[i], v.d[i], v.err[i]);
    check_resp(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bus.satp_ppn            = '0;
    bus.ptw_req_valid       = 1'b0;
    bus.ptw_req_trans_id    = '0;
    bus.ptw_req_vpn         = '0;
    bus.ptw_req_access_type = '0;
    bus.mem_req_ready       = 1'b1;
    bus.mem_resp_valid      = 1'b0;
    bus.mem_resp_data       = '0;
    bus.mem_resp_err        = 1'b0;
    bus.ptw_resp_ready      = 1'b1;

    vecs[0]  = mk(4'd3, 2'b01, 2'd3, 64'h20000401, 64'h20000801,
                  64'h240000CF, 3'b000, 0, 4'd0, 2'd0, 64'h240000CF);
    vecs[1]  = mk(4'd5, 2'b01, 2'd1, 64'h200000CF, 0, 0,
                  3'b000, 0, 4'd0, 2'd2, 64'h200000CF);
    vecs[2]  = mk(4'd6, 2'b01, 2'd1, 64'h200004CF, 0, 0,
                  3'b000, 1, 4'd13, 2'd2, 64'd0);
    vecs[3]  = mk(4'd7, 2'b01, 2'd1, 64'h0, 0, 0,
                  3'b000, 1, 4'd13, 2'd2, 64'd0);
    vecs[4]  = mk(4'd8, 2'b10, 2'd3, 64'h20000401, 64'h20000801,
                  64'h2400004F, 3'b000, 1, 4'd15, 2'd0, 64'd0);
    vecs[5]  = mk(4'd9, 2'b00, 2'd3, 64'h20000401, 64'h20000801,
                  64'h20000C01, 3'b000, 1, 4'd12, 2'd0, 64'd0);
    vecs[6]  = mk(4'd10, 2'b00, 2'd2, 64'h20000401, 64'hDEADBEEF, 0,
                  3'b010, 1, 4'd1, 2'd1, 64'd0);
    vecs[7]  = mk(4'd11, 2'b11, 2'd1, 64'h200000CF, 0, 0,
                  3'b000, 0, 4'd0, 2'd2, 64'h200000CF);
    vecs[8]  = mk(4'd12, 2'b01, 2'd1, 64'h5, 0, 0,
                  3'b000, 1, 4'd13, 2'd2, 64'd0);
    vecs[9]  = mk(4'd13, 2'b00, 2'd1, 64'h00400000_200000CF, 0, 0,
                  3'b000, 1, 4'd12, 2'd2, 64'd0);
    vecs[10] = mk(4'd14, 2'b10, 2'd1, 64'h200000CF, 0, 0,
                  3'b001, 1, 4'd7, 2'd2, 64'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.ptw_req_ready, 1);
    chk("rst_mem_valid", bus.mem_req_valid, 0);
    chk("rst_resp_valid", bus.ptw_resp_valid, 0);
    chk("rst_pte", bus.ptw_resp_pte, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // memory and response backpressure, with a competing request
    v = vecs[0];
    bus.mem_req_ready = 1'b0;
    send_req(v);
    bus.ptw_req_valid    = 1'b1;
    bus.ptw_req_trans_id = 4'd15;
    for (int i = 0; i < 5; i++) begin
      chk("bp_mem_valid", bus.mem_req_valid, 1);
      chk("bp_paddr", bus.mem_req_paddr, 56'h80000008);
      chk("bp_req_ready", bus.ptw_req_ready, 0);
      @(negedge clk);
    end
    bus.ptw_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    serve_read(v.a[0], v.d[0], 1'b0);
    serve_read(v.a[1], v.d[1], 1'b0);
    bus.ptw_resp_ready = 1'b0;
    serve_read(v.a[2], v.d[2], 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_resp_valid", bus.ptw_resp_valid, 1);
      chk("bp_resp_pte", bus.ptw_resp_pte, 64'h240000CF);
      chk("bp_resp_tid", bus.ptw_resp_trans_id, 4'd3);
      chk("bp_resp_req_ready", bus.ptw_req_ready, 0);
      @(negedge clk);
    end
    bus.ptw_resp_ready = 1'b1;
    check_resp(v);

    // reset while waiting for a PTE, then a stale response
    send_req(vecs[1]);
    @(negedge clk);
    chk("mr_in_wait", bus.mem_req_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h200000CF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("mr_req_ready", bus.ptw_req_ready, 1);
    chk("mr_mem_valid", bus.mem_req_valid, 0);
    chk("mr_resp_valid", bus.ptw_resp_valid, 0);
    chk("mr_resp_pte", bus.ptw_resp_pte, 0);
    chk("mr_resp_tid", bus.ptw_resp_trans_id, 0);
    chk("mr_resp_ex", bus.ptw_resp_excp_valid, 0);
    chk("mr_resp_lvl", bus.ptw_resp_lvl, 0);
    chk("mr_paddr", bus.mem_req_paddr, 0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
